icache_direct_mapped: RTL and testbench
=======================================

# icache_direct_mapped

Direct-mapped instruction cache between the CPU fetch stage and the 128-bit block instruction memory. Serves 32-bit instruction reads from the PC in the same cycle on a hit. On a miss, stalls the CPU with `busywait` and refills one 16-byte line from memory through a `read`/`busywait` handshake. Supports a whole-cache `flush` so the OS can invalidate lines on a context switch.

## Interface
- `INDEX_BITS`, default 3: line index width; line count is 2^INDEX_BITS (8); tag width is 28-INDEX_BITS.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all valid bits and the FSM.
- `address`  in  32  CPU byte PC. [1:0] ignored; [3:2] selects the word; [3+INDEX_BITS:4] is the index; [31:4+INDEX_BITS] is the tag.
- `read`  in  1  CPU fetch request; held high until `busywait` is low.
- `flush`  in  1  one-cycle pulse; invalidates every line.
- `instruction`  out  32  selected word on a hit, otherwise 32'h0.
- `busywait`  out  1  CPU stall.
- `mem_read`  out  1  memory read request.
- `mem_address`  out  28  block address = `address[31:4]`.
- `mem_readdata`  in  128  refill block; byte 0 is in [7:0] and word n is in [32n+31:32n].
- `mem_busywait`  in  1  memory stall; low in the cycle the last byte is captured.

## Operation
- Storage per line: valid bit, tag, and 128-bit data. `hit` = valid[index] && tag match, evaluated combinationally.
- FSM states and transitions:
  - IDLE: if `read && !hit`, go to MEM_READ; otherwise stay in IDLE.
  - MEM_READ: drive `mem_read=1` and `mem_address=address[31:4]`. When `mem_busywait==0`, go to UPDATE.
  - UPDATE: `mem_read=0`. Write `mem_readdata` into the line, set valid, write the tag, then go to IDLE.
- Outputs by state:
  - `busywait = read && !(state==IDLE && hit)`.
  - `instruction` is the selected word only when in IDLE with a hit.
- `address` must stay stable while `busywait` is high; the cache does not latch it.
- Flush:
  - `flush` clears all valid bits at the next edge.
  - If `flush` and the UPDATE write land in the same cycle, the UPDATE line ends valid (fill wins for that line only).
  - A flush during MEM_READ does not abort the refill.
- Reset mid-refill: the FSM returns to IDLE and all lines become invalid. The memory block's own counter is not this block's concern; `mem_read` drops immediately.
- Reset values: state IDLE, all valid=0, `mem_read=0`, `mem_address` follows `address`, `instruction=0`, and `busywait=read`.

## Timing
- Hit: zero latency. `instruction` is valid and `busywait` is low in the request cycle.
- Miss, with the 16-cycle memory:
  - Cycle 0: miss detected.
  - Cycles 1–16: MEM_READ; `mem_busywait` goes low in cycle 16.
  - Cycle 17: UPDATE.
  - Cycle 18: hit, `busywait` low.
  - The miss penalty therefore equals memory latency + 2.
- `mem_read` is high for exactly the MEM_READ cycles, so the memory's byte counter wraps back to 0 after one block.
- Back-to-back misses to different lines each take the full penalty. There is no overlap and no prefetch.

## Configuration
- `ICACHE_PERF_CNT_EN`: when defined, the block adds two outputs.
  - `hit_count[15:0]` increments on each IDLE cycle with `read && hit`.
  - `miss_count[15:0]` increments on each IDLE→MEM_READ transition.
  - Both saturate at 16'hFFFF and clear on reset. `flush` does not clear them.
- When the macro is undefined, these ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Cold miss: memory bytes 0–3 = 93 01 81 c1, reset released, `read=1`, `address=0`.
  - Required: `busywait` is high for 18 cycles, `mem_read` is high for 16 cycles with `mem_address=0`, then `instruction=32'hc1810193` with `busywait=0`.
- Hit sequence: after the refill, `address=0x4`, `0x8`, `0xC` on consecutive cycles.
  - Required: words 1–3 of block 0 appear with `busywait=0` every cycle and `mem_read` stays 0.
- Conflict: with `INDEX_BITS=3`, fetch `0x000`, then `0x080` (same index, tag 1), then `0x000`.
  - Required: three misses, each at 18 cycles; `mem_address` = 0, then 8, then 0.
- Flush: hit on `0x0`, pulse `flush`, read `0x0`.
  - Required: a miss with a full refill; under `ICACHE_PERF_CNT_EN`, `miss_count=2` and `hit_count≥1`.
- Reset mid-refill: drive `reset=0` in cycle 8 of MEM_READ, release it, then read `0x0`.
  - Required: `mem_read` drops asynchronously, the state is IDLE, and the next read performs a full miss.
- Flush/UPDATE collision: assert `flush` in the UPDATE cycle.
  - Required: the refilled line hits on the next cycle; a line filled earlier then misses.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache sitting between the fetch stage and a 128-bit
// block instruction memory. Hits return the selected word in the same cycle; a
// miss stalls the CPU and refills one 16-byte line through a read/busywait handshake.
// Optional: define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module icache_direct_mapped #(
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  address,
  input  logic         read,
  input  logic         flush,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 28 - INDEX_BITS;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMemRead = 2'd1;
  localparam logic [1:0] StUpdate  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [Lines-1:0]      valid_q, valid_d;
  logic [TagBits-1:0]    tag_q  [Lines];
  logic [TagBits-1:0]    tag_d  [Lines];
  logic [127:0]          data_q [Lines];
  logic [127:0]          data_d [Lines];

  logic [INDEX_BITS-1:0] index;
  logic [TagBits-1:0]    tag;
  logic [1:0]            word;
  logic                  hit;
  logic                  idle_hit;
  logic                  unused_addr;

  assign index       = address[3+INDEX_BITS:4];
  assign tag         = address[31:4+INDEX_BITS];
  assign word        = address[3:2];
  // Byte offset within the word is irrelevant for word fetches.
  assign unused_addr = ^address[1:0];

  assign hit      = valid_q[index] && (tag_q[index] == tag);
  assign idle_hit = (state_q == StIdle) && hit;

  // Outputs are purely combinational so mem_read drops as soon as reset forces IDLE.
  always_comb begin
    instruction = idle_hit ? data_q[index][{word, 5'b00000} +: 32] : 32'h0;
    busywait    = read && !idle_hit;
    mem_read    = (state_q == StMemRead);
    mem_address = address[31:4];
  end

  // Refill FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (read && !hit) state_d = StMemRead;
      StMemRead: if (!mem_busywait) state_d = StUpdate;
      StUpdate:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Valid/tag/data next-state; the fill is applied after flush so the filled line survives.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (flush) valid_d = '0;
    if (state_q == StUpdate) begin
      valid_d[index] = 1'b1;
      tag_d[index]   = tag;
      data_d[index]  = mem_readdata;
    end
  end

  // Control state and valid bits, cleared by asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays need no reset; valid bits guard them.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating event counters; flush leaves them alone.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (read && idle_hit && (hit_count_q != 16'hFFFF)) hit_count_d = hit_count_q + 16'd1;
    if ((state_q == StIdle) && read && !hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: a 16-cycle block memory model plus a
// transaction-level cache model (valid/tag per line) predicting hit/miss, stall length
// and fetched word for directed and random fetch sequences.
module tb_icache_direct_mapped;

  localparam int Lines = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  address;
  logic         read;
  logic         flush;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int tests = 0;
  int fails = 0;

  // Reference cache contents: which block number each line holds.
  bit         mvalid [Lines];
  int         mblk   [Lines];
  int         model_hits = 0;
  int         model_misses = 0;

  icache_direct_mapped #(.INDEX_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .flush        (flush),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory contents: block 0 word 0 is the known opcode, everything else hashed.
  function automatic logic [31:0] mem_word(input logic [27:0] blk, input int n);
    if (blk == 28'd0 && n == 0) return 32'hc1810193;
    return ({4'h0, blk} * 32'h9E3779B1) ^ (n * 32'h85EBCA6B) ^ 32'h5bd1e995;
  endfunction

  always_comb begin
    for (int n = 0; n < 4; n++) mem_readdata[32*n +: 32] = mem_word(mem_address, n);
  end

  // 16-cycle memory: busywait drops in the 16th cycle of a read request.
  logic [4:0] mcnt;
  always @(posedge clock) begin
    if (!mem_read) mcnt <= 5'd0;
    else mcnt <= mcnt + 5'd1;
  end
  assign mem_busywait = !(mem_read && mcnt == 5'd15);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < Lines; i++) mvalid[i] = 1'b0;
  endtask

  // One CPU fetch; fl raises flush during the refill's UPDATE cycle (cycle 17).
  task automatic fetch(input logic [31:0] a, input bit fl);
    int  blk, idx, cyc, mr_cycles, addr_errs;
    bit  exp_hit;
    blk = int'(a >> 4);
    idx = blk % Lines;
    exp_hit = mvalid[idx] && (mblk[idx] == blk);
    address = a;
    read = 1'b1;
    cyc = 0;
    mr_cycles = 0;
    addr_errs = 0;
    @(negedge clock);
    while (busywait && cyc < 100) begin
      if (mem_read) begin
        mr_cycles++;
        if (mem_address !== a[31:4]) addr_errs++;
      end
      if (fl && cyc == 17) flush = 1'b1;
      cyc++;
      @(negedge clock);
    end
    flush = 1'b0;
    check($sformatf("stall_cycles@%0h", a), 128'(cyc), exp_hit ? 128'd0 : 128'd18);
    check($sformatf("mem_read_cycles@%0h", a), 128'(mr_cycles), exp_hit ? 128'd0 : 128'd16);
    check($sformatf("mem_address_errs@%0h", a), 128'(addr_errs), 128'd0);
    check($sformatf("instruction@%0h", a), 128'(instruction), 128'(mem_word(a[31:4], int'(a[3:2]))));
    check($sformatf("mem_read_idle@%0h", a), 128'(mem_read), 128'd0);
    if (!exp_hit) model_misses++;
    model_hits++;
    if (fl) model_clear();
    mvalid[idx] = 1'b1;
    mblk[idx] = blk;
    @(posedge clock);
    #1;
  endtask

  task automatic do_flush();
    read = 1'b0;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    int mr;
    logic [31:0] ra;
    model_clear();
    reset = 1'b0;
    read = 1'b1;
    flush = 1'b0;
    address = 32'h0000_0040;
    #3;
    check("reset_busywait", 128'(busywait), 128'd1);
    check("reset_mem_read", 128'(mem_read), 128'd0);
    check("reset_instruction", 128'(instruction), 128'd0);
    check("reset_mem_address", 128'(mem_address), 128'h4);
    read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Cold miss, then hits on the rest of the block.
    fetch(32'h0, 1'b0);
    check("cold_word0", 128'(instruction), 128'hc1810193);
    fetch(32'h4, 1'b0);
    fetch(32'h8, 1'b0);
    fetch(32'hC, 1'b0);

    // Conflict on index 0.
    fetch(32'h80, 1'b0);
    fetch(32'h0, 1'b0);

    // Flush forces a refill.
    fetch(32'h0, 1'b0);
    do_flush();
    fetch(32'h0, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_miss_after_flush", 128'(miss_count), 128'(model_misses));
    check("perf_hit_after_flush", 128'(hit_count), 128'(model_hits));
`endif

    // Flush colliding with UPDATE: the filled line survives, the older one does not.
    read = 1'b0;
    @(posedge clock);
    #1;
    fetch(32'h10, 1'b0);
    fetch(32'h20, 1'b1);
    fetch(32'h24, 1'b0);
    fetch(32'h10, 1'b0);

    // Reset in MEM_READ cycle 8.
    address = 32'h30;
    read = 1'b1;
    mr = 0;
    for (int i = 0; i < 40 && mr < 8; i++) begin
      @(negedge clock);
      if (mem_read) mr++;
    end
    check("mid_refill_reached", 128'(mr), 128'd8);
    reset = 1'b0;
    #1;
    check("mid_refill_mem_read_drop", 128'(mem_read), 128'd0);
    check("mid_refill_busywait", 128'(busywait), 128'd1);
    read = 1'b0;
    #1;
    check("mid_refill_busy_noread", 128'(busywait), 128'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_clear();
    model_hits = 0;
    model_misses = 0;
    fetch(32'h0, 1'b0);

    // Random fetches over 24 blocks so conflicts and hits both occur.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_flush();
      end else begin
        ra = {$urandom_range(0, 23), 4'h0};
        ra[3:0] = 4'($urandom_range(0, 15));
        fetch(ra, ($urandom_range(0, 7) == 0));
      end
    end

`ifdef ICACHE_PERF_CNT_EN
    check("perf_miss_final", 128'(miss_count), 128'(model_misses));
    check("perf_hit_final", 128'(hit_count), 128'(model_hits));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
